// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: Moore strobes decoded from the
// registered state, a run gate for new fetches, and a retired-instruction counter.
module mips_multicycle_control #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter logic [5:0]  OP_RTYPE    = 6'h00,
  parameter logic [5:0]  OP_LW       = 6'h23,
  parameter logic [5:0]  OP_SW       = 6'h2B,
  parameter logic [5:0]  OP_BEQ      = 6'h04,
  parameter logic [5:0]  OP_J        = 6'h02,
  parameter logic [5:0]  OP_ADDI     = 6'h08
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic [5:0]             opcode,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             PCSource,
  output logic [3:0]             state,
  output logic                   illegal_op,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    StInit    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAddr = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExec    = 4'd7,
    StRwb     = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StAddiEx  = 4'd11,
    StAddiWb  = 4'd12
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   terminal;
  logic                   legal_op;

  assign legal_op = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

  // Every terminal state lasts exactly one cycle, so being in one marks a retirement.
  assign terminal = (state_q == StMemWb) || (state_q == StMemWr) || (state_q == StRwb) ||
                    (state_q == StBranch) || (state_q == StJump) || (state_q == StAddiWb);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (terminal) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = StInit;
    case (state_q)
      StInit:    state_d = run ? StFetch : StInit;
      StFetch:   state_d = StDecode;
      StDecode: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = StMemAddr;
        else if (opcode == OP_RTYPE)                 state_d = StExec;
        else if (opcode == OP_BEQ)                   state_d = StBranch;
        else if (opcode == OP_J)                     state_d = StJump;
        else if (opcode == OP_ADDI)                  state_d = StAddiEx;
        else                                         state_d = run ? StFetch : StInit;
      end
      StMemAddr: state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   state_d = StMemWb;
      StExec:    state_d = StRwb;
      StAddiEx:  state_d = StAddiWb;
      StMemWb, StMemWr, StRwb, StBranch, StJump, StAddiWb:
                 state_d = run ? StFetch : StInit;
      default:   state_d = StInit;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      StDecode: begin
        ALUSrcB    = 2'b11;
        illegal_op = !legal_op;
      end
      StMemAddr, StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StRwb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      StAddiWb:  RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: a vector table walks every instruction class,
// with hand sequences for mid-instruction reset and counter wrap on a narrow instance.
module tb_mips_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n, reset_n2, run;
  logic [5:0]  opcode;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        w_pcw, w_pcwc, w_iord, w_mr, w_mw, w_irw, w_m2r, w_rd, w_rw, w_asa, w_ill;
  logic [1:0]  w_asb, w_aop, w_pcs;
  logic [3:0]  w_state;
  logic [1:0]  w_cnt;

  int tests = 0;
  int fails = 0;
  int mw_cycles = 0;
  int pwc_cycles = 0;

  always #5 clk = ~clk;

  mips_multicycle_control u_dut (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  mips_multicycle_control #(.COUNT_WIDTH(2)) u_wrap (
    .clk(clk), .reset_n(reset_n2), .run(run), .opcode(opcode),
    .PCWrite(w_pcw), .PCWriteCond(w_pcwc), .IorD(w_iord), .MemRead(w_mr),
    .MemWrite(w_mw), .IRWrite(w_irw), .MemtoReg(w_m2r), .RegDst(w_rd),
    .RegWrite(w_rw), .ALUSrcA(w_asa), .ALUSrcB(w_asb), .ALUOp(w_aop),
    .PCSource(w_pcs), .state(w_state), .illegal_op(w_ill), .instr_count(w_cnt)
  );

  logic [16:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

  // Expected strobe words, hand-derived per state in the ctl packing order above.
  localparam logic [16:0] CInit   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] CFetch  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] CDec    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] CDecIll = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] CMAddr  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] CMRd    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] CMWb    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] CMWr    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] CExec   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] CRwb    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] CBr     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] CJmp    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] CAWb    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  typedef struct {
    logic        run;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic [5:0] op, logic [3:0] st, logic [16:0] c,
                              logic [31:0] n);
    vec_t v;
    v.run = r; v.op = op; v.st = st; v.ctl = c; v.cnt = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op);
    @(negedge clk);
    run = r;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  // Invariants checked on every cycle of the main instance.
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      check("mem_rd_wr_exclusive", {31'b0, MemRead & MemWrite}, 32'd0);
      check("regwrite_in_fetch_decode", {31'b0, RegWrite & (state == 4'd1 || state == 4'd2)},
            32'd0);
      if (MemWrite) mw_cycles++;
      if (PCWriteCond) pwc_cycles++;
    end
  end

  initial begin
    reset_n = 1'b0; reset_n2 = 1'b0; run = 1'b0; opcode = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {28'b0, state}, 32'd0);
    check("reset_ctl", {15'b0, ctl}, {15'b0, CInit});
    check("reset_count", instr_count, 32'd0);

    @(negedge clk); reset_n = 1'b1;
    step(1'b1, 6'h00); check("pre_fetch", {28'b0, state}, 32'd1);
    step(1'b1, 6'h00); check("pre_decode", {28'b0, state}, 32'd2);
    step(1'b1, 6'h00); check("pre_exec", {28'b0, state}, 32'd7);
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("midexec_reset_state", {28'b0, state}, 32'd0);
    check("midexec_reset_ctl", {15'b0, ctl}, {15'b0, CInit});
    check("midexec_reset_count", instr_count, 32'd0);
    @(negedge clk); reset_n = 1'b1; run = 1'b1; opcode = 6'h23;
    @(posedge clk); #1;
    check("release_fetch_state", {28'b0, state}, 32'd1);
    check("release_fetch_ctl", {15'b0, ctl}, {15'b0, CFetch});
    check("release_count", instr_count, 32'd0);

    // LW
    vq.push_back(mk(1, 6'h23, 4'd2,  CDec,    0));
    vq.push_back(mk(1, 6'h23, 4'd3,  CMAddr,  0));
    vq.push_back(mk(1, 6'h23, 4'd4,  CMRd,    0));
    vq.push_back(mk(1, 6'h23, 4'd5,  CMWb,    0));
    vq.push_back(mk(1, 6'h23, 4'd1,  CFetch,  1));
    // R-type
    vq.push_back(mk(1, 6'h00, 4'd2,  CDec,    1));
    vq.push_back(mk(1, 6'h00, 4'd7,  CExec,   1));
    vq.push_back(mk(1, 6'h00, 4'd8,  CRwb,    1));
    vq.push_back(mk(1, 6'h00, 4'd1,  CFetch,  2));
    // SW
    vq.push_back(mk(1, 6'h2B, 4'd2,  CDec,    2));
    vq.push_back(mk(1, 6'h2B, 4'd3,  CMAddr,  2));
    vq.push_back(mk(1, 6'h2B, 4'd6,  CMWr,    2));
    vq.push_back(mk(1, 6'h2B, 4'd1,  CFetch,  3));
    // BEQ
    vq.push_back(mk(1, 6'h04, 4'd2,  CDec,    3));
    vq.push_back(mk(1, 6'h04, 4'd9,  CBr,     3));
    vq.push_back(mk(1, 6'h04, 4'd1,  CFetch,  4));
    // J
    vq.push_back(mk(1, 6'h02, 4'd2,  CDec,    4));
    vq.push_back(mk(1, 6'h02, 4'd10, CJmp,    4));
    vq.push_back(mk(1, 6'h02, 4'd1,  CFetch,  5));
    // ADDI
    vq.push_back(mk(1, 6'h08, 4'd2,  CDec,    5));
    vq.push_back(mk(1, 6'h08, 4'd11, CMAddr,  5));
    vq.push_back(mk(1, 6'h08, 4'd12, CAWb,    5));
    vq.push_back(mk(1, 6'h08, 4'd1,  CFetch,  6));
    // Illegal opcode with run high: one-cycle pulse, back to FETCH, no retirement
    vq.push_back(mk(1, 6'h3F, 4'd2,  CDecIll, 6));
    vq.push_back(mk(1, 6'h3F, 4'd1,  CFetch,  6));
    // run dropped during EXEC: RWB completes, then INIT holds until run returns
    vq.push_back(mk(1, 6'h00, 4'd2,  CDec,    6));
    vq.push_back(mk(1, 6'h00, 4'd7,  CExec,   6));
    vq.push_back(mk(0, 6'h00, 4'd8,  CRwb,    6));
    vq.push_back(mk(0, 6'h00, 4'd0,  CInit,   7));
    vq.push_back(mk(0, 6'h00, 4'd0,  CInit,   7));
    vq.push_back(mk(1, 6'h00, 4'd1,  CFetch,  7));
    // Illegal opcode with run low goes to INIT
    vq.push_back(mk(1, 6'h3F, 4'd2,  CDecIll, 7));
    vq.push_back(mk(0, 6'h3F, 4'd0,  CInit,   7));
    vq.push_back(mk(0, 6'h00, 4'd0,  CInit,   7));
    // run is ignored mid-instruction
    vq.push_back(mk(1, 6'h02, 4'd1,  CFetch,  7));
    vq.push_back(mk(0, 6'h02, 4'd2,  CDec,    7));
    vq.push_back(mk(0, 6'h02, 4'd10, CJmp,    7));
    vq.push_back(mk(0, 6'h02, 4'd0,  CInit,   8));

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].run, vq[i].op);
      check($sformatf("v%0d_state", i), {28'b0, state}, {28'b0, vq[i].st});
      check($sformatf("v%0d_ctl", i), {15'b0, ctl}, {15'b0, vq[i].ctl});
      check($sformatf("v%0d_count", i), instr_count, vq[i].cnt);
    end

    check("memwrite_cycles", mw_cycles, 32'd1);
    check("pcwritecond_cycles", pwc_cycles, 32'd1);

    // Counter wrap on a 2-bit instance: four J instructions take 3 -> 0
    @(negedge clk); reset_n2 = 1'b1;
    step(1'b1, 6'h02);
    check("wrap_fetch", {28'b0, w_state}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      repeat (3) step(1'b1, 6'h02);
      check($sformatf("wrap_count_%0d", k), {30'b0, w_cnt}, k % 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
